// File: rtl/inst_encoder_if.sv
// Loader-side bundle and instruction-memory write port of the RV32I instruction encoder.
// The master drives everything the encoder consumes; the slave is the encoder itself.
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [ADDR_W-2:0] count;
    logic              full;
    logic              err;

    modport master (
        output start, in_valid, op, rd, rs1, rs2, imm, wr_ready,
        input  in_ready, wr_en, wr_addr, wr_data, count, full, err
    );

    modport slave (
        input  start, in_valid, op, rd, rs1, rs2, imm, wr_ready,
        output in_ready, wr_en, wr_addr, wr_data, count, full, err
    );
endinterface

// File: rtl/inst_encoder.sv
// Encodes RV32I field bundles into machine words and streams them to consecutive
// instruction-memory words through a single-entry output register with backpressure.
module inst_encoder #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    inst_encoder_if.slave  bus
);
    localparam int unsigned CNT_W = ADDR_W - 1;
    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam logic [CNT_W-1:0] CAPACITY = {1'b1, {IDX_W{1'b0}}};

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;
    localparam logic [2:0] OP_LW   = 3'd6;
    localparam logic [2:0] OP_SW   = 3'd7;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_STOR = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FULL = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;

    logic signed [31:0] imm_s;
    logic [31:0]        enc_c;
    logic               legal_c;
    logic               in_ready_c;

    assign imm_s = $signed(bus.imm);

    // Field packing and immediate range check for the current bundle
    always_comb begin : encode
        legal_c = 1'b1;
        enc_c   = '0;
        unique case (bus.op)
            OP_ADD:  enc_c = {7'b0000000, bus.rs2, bus.rs1, 3'b000, bus.rd, OPC_R};
            OP_SUB:  enc_c = {7'b0100000, bus.rs2, bus.rs1, 3'b000, bus.rd, OPC_R};
            OP_AND:  enc_c = {7'b0000000, bus.rs2, bus.rs1, 3'b111, bus.rd, OPC_R};
            OP_OR:   enc_c = {7'b0000000, bus.rs2, bus.rs1, 3'b110, bus.rd, OPC_R};
            OP_BEQ: begin
                enc_c   = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b000,
                           bus.imm[4:1], bus.imm[11], OPC_BR};
                legal_c = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !bus.imm[0];
            end
            OP_ADDI: begin
                enc_c   = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, OPC_IMM};
                legal_c = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            OP_LW: begin
                enc_c   = {bus.imm[11:0], bus.rs1, 3'b010, bus.rd, OPC_LOAD};
                legal_c = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            OP_SW: begin
                enc_c   = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b010, bus.imm[4:0], OPC_STOR};
                legal_c = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            default: enc_c = '0;
        endcase
    end

    // Next-state: accept, retire, capacity tracking; start overrides everything
    always_comb begin : next_state
        state_d    = state_q;
        count_d    = count_q;
        err_d      = err_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        in_ready_c = 1'b0;

        if (wr_en_q && bus.wr_ready) begin
            wr_en_d = 1'b0;
        end

        unique case (state_q)
            RUN: begin
                in_ready_c = (count_q < CAPACITY) && (!wr_en_q || bus.wr_ready) && !bus.start;
                if (bus.in_valid && in_ready_c) begin
                    if (legal_c) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {count_q[IDX_W-1:0], 2'b00};
                        wr_data_d = enc_c;
                        count_d   = count_q + CNT_W'(1);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // Full as soon as the last word has left the output register
                if ((count_d == CAPACITY) && !wr_en_d) begin
                    state_d = FULL;
                end
            end
            default: ;
        endcase

        if (bus.start) begin
            state_d = RUN;
            count_d = '0;
            err_d   = 1'b0;
            wr_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.in_ready = in_ready_c;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.count    = count_q;
    assign bus.full     = (state_q == FULL);
    assign bus.err      = err_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: vector table, directed corner sequences,
// and randomized traffic against a behavioural model of the loader protocol.
module tb_inst_encoder;
    localparam int unsigned ADDR_W = 4;
    localparam int CAP = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    inst_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    inst_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          op;
        int          rd;
        int          rs1;
        int          rs2;
        int          imm;
        logic [31:0] data;
        bit          legal;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit ref_legal(input int op, input int imm);
        if (op == 4) return (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
        if (op >= 5) return (imm >= -2048) && (imm <= 2047);
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input int imm);
        logic [31:0] u;
        logic [31:0] w;
        u = 32'(imm);
        w = 32'(rs1) << 15;
        case (op)
            0, 1, 2, 3: begin
                w += 32'h33 + (32'(rd) << 7) + (32'(rs2) << 20);
                if (op == 1) w += 32'h4000_0000;
                if (op == 2) w += 32'h7000;
                if (op == 3) w += 32'h6000;
            end
            4: w += 32'h63 + (32'(rs2) << 20) + (((u >> 12) & 1) << 31)
                  + (((u >> 5) & 32'h3F) << 25) + (((u >> 1) & 32'hF) << 8)
                  + (((u >> 11) & 1) << 7);
            5: w += 32'h13 + (32'(rd) << 7) + ((u & 32'hFFF) << 20);
            6: w += 32'h03 + 32'h2000 + (32'(rd) << 7) + ((u & 32'hFFF) << 20);
            default: w += 32'h23 + 32'h2000 + (32'(rs2) << 20)
                        + (((u >> 5) & 32'h7F) << 25) + ((u & 32'h1F) << 7);
        endcase
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 3'd0;
        bus.rd       = 5'd0;
        bus.rs1      = 5'd0;
        bus.rs2      = 5'd0;
        bus.imm      = 32'd0;
    endtask

    task automatic set_bundle(input int op, input int rd, input int rs1, input int rs2,
                              input int imm);
        bus.in_valid = 1'b1;
        bus.op       = 3'(op);
        bus.rd       = 5'(rd);
        bus.rs1      = 5'(rs1);
        bus.rs2      = 5'(rs2);
        bus.imm      = 32'(imm);
    endtask

    task automatic do_start();
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({name, ".wr_en"},    32'(bus.wr_en),    32'd0);
        chk({name, ".wr_addr"},  32'(bus.wr_addr),  32'd0);
        chk({name, ".wr_data"},  bus.wr_data,       32'd0);
        chk({name, ".count"},    32'(bus.count),    32'd0);
        chk({name, ".full"},     32'(bus.full),     32'd0);
        chk({name, ".err"},      32'(bus.err),      32'd0);
    endtask

    // Behavioural model state: mode 0 idle, 1 loading, 2 full
    int          m_mode;
    int          m_cnt;
    bit          m_err;
    bit          m_pend;
    logic [31:0] m_addr;
    logic [31:0] m_data;

    task automatic random_phase(input int cycles);
        bit st, iv, wr, exp_ready;
        int op, rd, rs1, rs2, imm;
        m_mode = 0; m_cnt = 0; m_err = 0; m_pend = 0; m_addr = '0; m_data = '0;
        for (int c = 0; c < cycles; c++) begin
            st  = ($urandom_range(0, 19) == 0);
            iv  = ($urandom_range(0, 9) < 6);
            wr  = ($urandom_range(0, 9) < 6);
            op  = int'($urandom_range(0, 7));
            rd  = int'($urandom_range(0, 31));
            rs1 = int'($urandom_range(0, 31));
            rs2 = int'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0: imm = int'($urandom_range(0, 200)) - 100;
                1: imm = int'($urandom_range(2045, 2050));
                2: imm = -int'($urandom_range(2046, 2051));
                3: imm = int'($urandom_range(4090, 4100));
                4: imm = -int'($urandom_range(4090, 4100));
                default: imm = int'($urandom);
            endcase
            set_bundle(op, rd, rs1, rs2, imm);
            bus.in_valid = iv;
            bus.start    = st;
            bus.wr_ready = wr;
            #1;
            exp_ready = (m_mode == 1) && (m_cnt < CAP) && (!m_pend || wr) && !st;
            chk("rnd.in_ready", 32'(bus.in_ready), 32'(exp_ready));
            if (st) begin
                m_mode = 1; m_cnt = 0; m_err = 0; m_pend = 0;
            end else begin
                if (m_pend && wr) m_pend = 0;
                if (iv && exp_ready) begin
                    if (ref_legal(op, imm)) begin
                        m_pend = 1;
                        m_addr = 32'(m_cnt * 4);
                        m_data = ref_enc(op, rd, rs1, rs2, imm);
                        m_cnt++;
                    end else begin
                        m_err = 1;
                    end
                end
                if (m_mode == 1 && m_cnt == CAP && !m_pend) m_mode = 2;
            end
            tick();
            chk("rnd.wr_en", 32'(bus.wr_en), 32'(m_pend));
            chk("rnd.count", 32'(bus.count), 32'(m_cnt));
            chk("rnd.err",   32'(bus.err),   32'(m_err));
            chk("rnd.full",  32'(bus.full),  32'(m_mode == 2));
            if (m_pend) begin
                chk("rnd.wr_addr", 32'(bus.wr_addr), m_addr);
                chk("rnd.wr_data", bus.wr_data, m_data);
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        bus.wr_ready = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        #1;
        chk("idle.in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        tick();

        // Single-bundle vector table, one load per vector
        vecs.push_back('{5, 1, 0, 0, 5, 32'h00500093, 1'b1});
        vecs.push_back('{1, 3, 1, 2, 0, 32'h402081B3, 1'b1});
        vecs.push_back('{4, 0, 1, 2, -4, 32'hFE208EE3, 1'b1});
        vecs.push_back('{7, 0, 0, 2, 8, 32'h00202423, 1'b1});
        vecs.push_back('{0, 5, 6, 7, 0, 32'h007302B3, 1'b1});
        vecs.push_back('{2, 1, 2, 3, 0, 32'h003170B3, 1'b1});
        vecs.push_back('{3, 31, 31, 31, 0, 32'h01FFEFB3, 1'b1});
        vecs.push_back('{6, 2, 3, 0, 2047, 32'h7FF1A103, 1'b1});
        vecs.push_back('{5, 1, 1, 0, -2048, 32'h80008093, 1'b1});
        vecs.push_back('{4, 0, 0, 0, 4094, 32'h7E000FE3, 1'b1});
        vecs.push_back('{4, 0, 0, 0, -4096, 32'h80000063, 1'b1});
        vecs.push_back('{5, 1, 0, 0, 2048, 32'h0, 1'b0});
        vecs.push_back('{4, 0, 1, 2, 3, 32'h0, 1'b0});
        vecs.push_back('{4, 0, 1, 2, 4096, 32'h0, 1'b0});
        vecs.push_back('{4, 0, 1, 2, -4098, 32'h0, 1'b0});
        vecs.push_back('{7, 0, 1, 2, -2049, 32'h0, 1'b0});
        bus.wr_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            do_start();
            set_bundle(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
            #1;
            chk("vec.in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            bus.in_valid = 1'b0;
            chk("vec.wr_en", 32'(bus.wr_en), 32'(vecs[i].legal));
            chk("vec.count", 32'(bus.count), 32'(vecs[i].legal));
            chk("vec.err",   32'(bus.err),   32'(!vecs[i].legal));
            if (vecs[i].legal) begin
                chk("vec.wr_addr", 32'(bus.wr_addr), 32'd0);
                chk("vec.wr_data", bus.wr_data, vecs[i].data);
            end
        end

        // SUB then BEQ back-to-back
        do_start();
        set_bundle(1, 3, 1, 2, 0);
        tick();
        set_bundle(4, 0, 1, 2, -4);
        #1;
        chk("b2b.in_ready", 32'(bus.in_ready), 32'd1);
        chk("b2b.data0", bus.wr_data, 32'h402081B3);
        chk("b2b.addr0", 32'(bus.wr_addr), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        chk("b2b.wr_en1", 32'(bus.wr_en), 32'd1);
        chk("b2b.addr1", 32'(bus.wr_addr), 32'd4);
        chk("b2b.data1", bus.wr_data, 32'hFE208EE3);
        chk("b2b.count", 32'(bus.count), 32'd2);
        tick();
        chk("b2b.drain", 32'(bus.wr_en), 32'd0);

        // SW held under backpressure
        do_start();
        bus.wr_ready = 1'b0;
        set_bundle(7, 0, 0, 2, 8);
        tick();
        set_bundle(5, 1, 0, 0, 5);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp.wr_en", 32'(bus.wr_en), 32'd1);
            chk("bp.wr_data", bus.wr_data, 32'h00202423);
            chk("bp.wr_addr", 32'(bus.wr_addr), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b1;
        tick();
        chk("bp.retire", 32'(bus.wr_en), 32'd0);
        chk("bp.count", 32'(bus.count), 32'd1);

        // Illegal immediates leave the address stream untouched
        do_start();
        set_bundle(5, 1, 0, 0, 2048);
        tick();
        chk("ill.err", 32'(bus.err), 32'd1);
        chk("ill.wr_en", 32'(bus.wr_en), 32'd0);
        chk("ill.count", 32'(bus.count), 32'd0);
        set_bundle(5, 1, 0, 0, 5);
        tick();
        chk("ill.next_en", 32'(bus.wr_en), 32'd1);
        chk("ill.next_addr", 32'(bus.wr_addr), 32'd0);
        chk("ill.next_data", bus.wr_data, 32'h00500093);
        set_bundle(4, 0, 1, 2, 3);
        tick();
        bus.in_valid = 1'b0;
        chk("ill.beq_err", 32'(bus.err), 32'd1);
        chk("ill.beq_count", 32'(bus.count), 32'd1);
        chk("ill.beq_en", 32'(bus.wr_en), 32'd0);

        // Fill to capacity
        do_start();
        for (int k = 0; k < CAP; k++) begin
            set_bundle(5, k + 1, 0, 0, k);
            #1;
            chk("fill.in_ready", 32'(bus.in_ready), 32'd1);
            tick();
            chk("fill.wr_en", 32'(bus.wr_en), 32'd1);
            chk("fill.wr_addr", 32'(bus.wr_addr), 32'(k * 4));
            chk("fill.wr_data", bus.wr_data, ref_enc(5, k + 1, 0, 0, k));
        end
        #1;
        chk("fill.ready_cap", 32'(bus.in_ready), 32'd0);
        chk("fill.full_early", 32'(bus.full), 32'd0);
        tick();
        chk("fill.full", 32'(bus.full), 32'd1);
        chk("fill.drained", 32'(bus.wr_en), 32'd0);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("fill.no_accept", 32'(bus.in_ready), 32'd0);
            tick();
            chk("fill.count_hold", 32'(bus.count), 32'(CAP));
            chk("fill.no_word", 32'(bus.wr_en), 32'd0);
        end
        bus.in_valid = 1'b0;

        // Restart with a pending word; start beats a simultaneous bundle
        do_start();
        set_bundle(5, 1, 0, 0, 4000);
        tick();
        bus.wr_ready = 1'b0;
        set_bundle(5, 1, 0, 0, 5);
        tick();
        chk("rst.pending", 32'(bus.wr_en), 32'd1);
        bus.start = 1'b1;
        set_bundle(0, 1, 2, 3, 0);
        #1;
        chk("rst.start_wins", 32'(bus.in_ready), 32'd0);
        tick();
        idle_inputs();
        chk("rst.wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst.count", 32'(bus.count), 32'd0);
        chk("rst.err", 32'(bus.err), 32'd0);

        // Asynchronous reset mid-load
        set_bundle(5, 1, 0, 0, 5);
        tick();
        bus.in_valid = 1'b0;
        chk("arst.loaded", 32'(bus.wr_en), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("arst");
        tick();
        reset = 1'b0;
        bus.wr_ready = 1'b1;
        set_bundle(5, 1, 0, 0, 5);
        #1;
        chk("arst.idle_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("arst.idle_no_word", 32'(bus.wr_en), 32'd0);
        idle_inputs();

        // Randomized traffic against the model, from a clean reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        random_phase(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

- Encodes RV32I instruction fields (R-type ADD/SUB/AND/OR, BEQ, ADDI, LW, SW) into 32-bit machine words. It is the encoding counterpart of the datapath's opcode/immediate decoder.
- Writes each encoded word to consecutive word addresses of instruction memory through a single-entry output register with backpressure.
- Sits between the test/boot loader and the instruction memory write port. It fills program memory before the core is released.

## Interface
- ADDR_W, 8, byte-address width of instruction memory; capacity = 2^(ADDR_W-2) words
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a new load at address 0
- in_valid  in  1  input field bundle valid
- in_ready  out  1  encoder accepts bundle this cycle
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 BEQ, 5 ADDI, 6 LW, 7 SW
- rd, rs1, rs2  in  5 each  register indices
- imm  in  32  signed immediate (byte offset for BEQ)
- wr_en  out  1  output word valid
- wr_ready  in  1  memory accepts word
- wr_addr  out  ADDR_W  byte address of word, multiple of 4
- wr_data  out  32  encoded instruction
- count  out  ADDR_W-1  legal words accepted since start
- full  out  1  capacity reached and output drained
- err  out  1  sticky; an illegal bundle was seen since start

## Operation
- **States:** IDLE, RUN, FULL. Reset enters IDLE.
- **start**, from any state:
  - Enters RUN.
  - Clears count and err.
  - Discards any pending output word (wr_en=0 next cycle).
- **in_ready:**
  - RUN: in_ready = (count < capacity) && (!wr_en || wr_ready) && !start.
  - IDLE and FULL: in_ready = 0.
- **Accept:** occurs when in_valid && in_ready.
- **Legal bundle:**
  - Load the output register: wr_data = encoding, wr_addr = count*4, wr_en=1.
  - Increment count.
- **Illegal bundle:**
  - Set err. No output word, count unchanged.
  - Illegal means: ADDI/LW/SW imm outside [-2048, 2047]; BEQ imm outside [-4096, 4094] or imm[0]=1.
- **Retire:** when wr_en && wr_ready, the word retires. wr_en drops unless a new word loads in the same cycle; a same-cycle reload is allowed (full throughput).
- **RUN → FULL:** when count == capacity and wr_en == 0. full = 1 only in FULL.
- **Encodings** (unused fields zero):
  - R-type: opcode 0110011, rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
    - ADD: funct3 000, funct7 0000000.
    - SUB: funct3 000, funct7 0100000.
    - AND: funct3 111, funct7 0000000.
    - OR: funct3 110, funct7 0000000.
  - BEQ: opcode 1100011, funct3 000, rd ignored. Fields: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - ADDI: opcode 0010011, funct3 000, [31:20]=imm[11:0], rs2 ignored.
  - LW: opcode 0000011, funct3 010, [31:20]=imm[11:0], rs2 ignored.
  - SW: opcode 0100011, funct3 010, [31:25]=imm[11:5], [11:7]=imm[4:0], rd ignored.
- **Simultaneous start and in_valid:** start wins; the bundle is not accepted.

## Timing
- **Reset values:** in_ready=0, wr_en=0, wr_addr=0, wr_data=0, count=0, full=0, err=0; state IDLE.
- **Latency:** a bundle accepted at edge N drives wr_en/wr_addr/wr_data after edge N.
- **Backpressure hold:** while wr_en && !wr_ready, wr_addr and wr_data hold stable.
- **err:** rises the cycle after the illegal accept and stays set until start or reset.
- **full:** rises the cycle after the last word retires.
- **Reset mid-load:** asynchronous reset returns all outputs to their reset values immediately. Pending words are lost.

## Test plan
- **ADDI:** reset, start, ADDI rd=1 rs1=0 imm=5 with wr_ready=1 → wr_en one cycle later, wr_addr=0x00, wr_data=0x00500093, count=1.
- **SUB then BEQ:** SUB rd=3 rs1=1 rs2=2 → 0x402081B3 at addr 0x00. Then BEQ rs1=1 rs2=2 imm=-4 → 0xFE208EE3 at addr 0x04. Back-to-back accepts, no bubble.
- **SW:** rs1=0 rs2=2 imm=8 → 0x00202423. Hold wr_ready=0 for 3 cycles → wr_en=1 and data stable; in_ready=0 throughout; retires on the first cycle wr_ready=1.
- **Illegal immediates:** ADDI imm=2048 → err=1, no wr_en, count unchanged; next legal word uses the unchanged address. BEQ imm=3 → err stays 1.
- **Fill to capacity:** ADDR_W=4, 4 legal words → addresses 0,4,8,12. in_ready=0 after the 4th accept, full=1 after its retire; a 5th bundle is never accepted.
- **Restart and reset:** start while a word is pending with wr_ready=0 → wr_en=0, count=0, err=0 next cycle. Reset asserted mid-RUN → all outputs 0 asynchronously; state IDLE.
